// File: rtl/mips_ext_pkg.sv
// Shared encodings for immediate extension: the extension modes seen by decode
// and the occupancy states of the two-entry output stage.
package mips_ext_pkg;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'd0,
      EXT_ZERO   = 2'd1,
      EXT_UPPER  = 2'd2,
      EXT_BRANCH = 2'd3
   } ext_mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension (sign, zero, upper-half, branch offset).
// Kept free of state so the decode stage can reuse it directly.
module imm_extend_core
   import mips_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic [OUT_W-1:0] out_data
);

   localparam int PAD_W = OUT_W - IN_W;

   if (IN_W < 2 || IN_W > OUT_W - 1 || OUT_W > 64) begin : g_bad_params
      $error("imm_extend_core: illegal IN_W=%0d / OUT_W=%0d", IN_W, OUT_W);
   end

   logic [OUT_W-1:0] sign_ext;
   assign sign_ext = {{PAD_W{in_data[IN_W-1]}}, in_data};

   always_comb begin
      // NOTE: default assignment first so no mode value can leave out_data unassigned (no latch).
      out_data = sign_ext;
      case (ext_mode_e'(in_mode))
         EXT_SIGN:   out_data = sign_ext;
         EXT_ZERO:   out_data = {{PAD_W{1'b0}}, in_data};
         EXT_UPPER:  out_data = {in_data, {PAD_W{1'b0}}};
         EXT_BRANCH: out_data = {sign_ext[OUT_W-3:0], 2'b00};
         default:    out_data = sign_ext;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension behind a valid/ready handshake with a primary + skid
// output stage, so in_ready comes from a flop and never from out_ready.
module imm_extend_pipe
   import mips_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   pipe_state_e      state;
   logic [OUT_W-1:0] ext_result;
   logic [OUT_W-1:0] primary;
   logic [OUT_W-1:0] skid;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             in_xfer;
   logic             out_xfer;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_data (ext_result)
   );

   assign in_xfer   = in_valid && in_ready_r;
   assign out_xfer  = out_valid_r && out_ready;
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = primary;

   // Handshake flags are written alongside every state change so they always
   // equal (state != ST_TWO) and (state != ST_EMPTY) without a decode after the flop.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         state       <= ST_EMPTY;
         primary     <= '0;
         skid        <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_xfer) begin
                  primary     <= ext_result;
                  state       <= ST_ONE;
                  out_valid_r <= 1'b1;
               end
            end
            ST_ONE: begin
               case ({in_xfer, out_xfer})
                  2'b10: begin
                     skid       <= ext_result;
                     state      <= ST_TWO;
                     in_ready_r <= 1'b0;
                  end
                  2'b01: begin
                     state       <= ST_EMPTY;
                     out_valid_r <= 1'b0;
                  end
                  2'b11: primary <= ext_result;
                  default: ;
               endcase
            end
            ST_TWO: begin
               if (out_xfer) begin
                  primary    <= skid;
                  state      <= ST_ONE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed results for both default and 8->16 widths.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [7:0]  s_in_data;
   logic [1:0]  s_in_mode;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [15:0] s_out_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_mode   (s_in_mode),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Extension rules as plain integer arithmetic on a 16-bit immediate.
   function automatic logic [31:0] model(input logic [1:0] mode, input logic [15:0] d);
      longint s;
      longint r;
      s = longint'(d);
      if (d >= 16'h8000) s = s - 65536;
      case (mode)
         2'd0:    r = s;
         2'd1:    r = longint'(d);
         2'd2:    r = longint'(d) * 65536;
         default: r = s * 4;
      endcase
      return r[31:0];
   endfunction

   // Reference queue: contents are exactly the results the DUT must still emit.
   logic [31:0] exp_q[$];
   bit          armed = 1'b0;
   int          accepted = 0;

   always @(negedge clk) begin
      if (armed && !rst) begin
         check("occupancy_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
         check("occupancy_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
         if (out_valid && exp_q.size() > 0)
            check("stream_out_data", 64'(out_data), 64'(exp_q[0]));
         if (out_valid && out_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_mode, in_data));
            accepted++;
         end
      end
      if (rst) begin
         exp_q.delete();
         armed = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat with out_ready high and check it appears exactly one cycle later.
   task automatic beat_direct(input string name, input logic [1:0] mode,
                              input logic [15:0] d, input logic [31:0] exp);
      in_valid  = 1'b1;
      in_mode   = mode;
      in_data   = d;
      out_ready = 1'b1;
      @(negedge clk);
      check({name, "_accept"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_data"}, 64'(out_data), 64'(exp));
      tick();
   endtask

   task automatic beat_small(input string name, input logic [1:0] mode,
                             input logic [7:0] d, input logic [15:0] exp);
      s_in_valid = 1'b1;
      s_in_mode  = mode;
      s_in_data  = d;
      @(negedge clk);
      check({name, "_accept"}, 64'(s_in_ready), 64'd1);
      tick();
      s_in_valid = 1'b0;
      @(negedge clk);
      check({name, "_valid"}, 64'(s_out_valid), 64'd1);
      check({name, "_data"}, 64'(s_out_data), 64'(exp));
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int start_acc;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_mode = '0; s_out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_data", 64'(out_data), 64'd0);
      tick();
      rst = 1'b0;

      // Hand-computed vectors at default widths.
      beat_direct("sign_8001", 2'd0, 16'h8001, 32'hFFFF8001);
      beat_direct("zero_8001", 2'd1, 16'h8001, 32'h00008001);
      beat_direct("upper_1234", 2'd2, 16'h1234, 32'h12340000);
      beat_direct("branch_ffff", 2'd3, 16'hFFFF, 32'hFFFFFFFC);
      beat_direct("branch_4000", 2'd3, 16'h4000, 32'h00010000);
      check("model_pin_sign", 64'(model(2'd0, 16'h8001)), 64'hFFFF8001);
      check("model_pin_branch", 64'(model(2'd3, 16'h4000)), 64'h00010000);

      // Backpressure: three beats offered with out_ready low.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'd0; in_data = 16'h0001;
      @(negedge clk);
      check("bp_accept1", 64'(in_ready), 64'd1);
      tick();
      in_mode = 2'd1; in_data = 16'hFFFF;
      @(negedge clk);
      check("bp_accept2", 64'(in_ready), 64'd1);
      check("bp_hold_b1a", 64'(out_data), 64'h00000001);
      tick();
      in_mode = 2'd2; in_data = 16'hABCD;
      repeat (3) begin
         @(negedge clk);
         check("bp_full_in_ready", 64'(in_ready), 64'd0);
         check("bp_hold_b1", 64'(out_data), 64'h00000001);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_emit1", 64'(out_data), 64'h00000001);
      check("bp_still_full", 64'(in_ready), 64'd0);
      tick();
      @(negedge clk);
      check("bp_ready_back", 64'(in_ready), 64'd1);
      check("bp_emit2", 64'(out_data), 64'h0000FFFF);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_emit3", 64'(out_data), 64'hABCD0000);
      tick();
      @(negedge clk);
      check("bp_drained", 64'(out_valid), 64'd0);
      tick();

      // Full throughput with out_ready held high.
      start_acc = accepted;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_mode = 2'(i);
         in_data = 16'(i * 16'h1111);
         tick();
      end
      in_valid = 1'b0;
      check("throughput_beats", 64'(accepted - start_acc), 64'd16);
      repeat (2) tick();

      // Reset while both registers are full, with a beat offered in the same cycle.
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'd0; in_data = 16'h1111;
      tick();
      in_data = 16'h2222;
      tick();
      @(negedge clk);
      check("pre_rst_full", 64'(in_ready), 64'd0);
      tick();
      rst = 1'b1;
      in_data = 16'h3333;
      tick();
      @(negedge clk);
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      beat_direct("post_rst_7fff", 2'd0, 16'h7FFF, 32'h00007FFF);

      // Random handshakes across all modes.
      start_acc = accepted;
      cyc = 0;
      while (accepted - start_acc < 3000 && cyc < 40000) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_mode   = 2'($urandom_range(0, 3));
         in_data   = 16'($urandom);
         tick();
         cyc++;
      end
      check("random_beats_accepted", 64'(accepted - start_acc >= 3000), 64'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         tick();
         cyc++;
      end
      @(negedge clk);
      check("random_drain_queue", 64'(exp_q.size()), 64'd0);
      check("random_drain_valid", 64'(out_valid), 64'd0);
      tick();

      // Narrow instance: 8-bit immediate into 16 bits.
      beat_small("s_sign_80", 2'd0, 8'h80, 16'hFF80);
      beat_small("s_upper_ab", 2'd2, 8'hAB, 16'hAB00);
      beat_small("s_zero_80", 2'd1, 8'h80, 16'h0080);
      beat_small("s_branch_ff", 2'd3, 8'hFF, 16'hFFFC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
